issue_fifo_bank: RTL and testbench
==================================

ISSUE_FIFO_BANK -- requirements
Module: issue_fifo_bank

Interface
- REQ-001 Parameter NUM_CH, default 3: number of independent issue channels (0=ALU, 1=LS, 2=BRANCH).
- REQ-002 Parameter ENTRY_W, default $bits(RS_ENTRY_t): payload width per channel.
- REQ-003 Parameter DEPTH, default 4: entries per channel; power of two, >=2.
- REQ-004 Parameter BYPASS, default 1: 1 enables same-cycle pass-through when a channel is empty.
- REQ-005 clk  input  1  single clock; all state on rising edge.
- REQ-006 rst  input  1  reset, asynchronous, active-low.
- REQ-007 flush  input  1  pipeline flush; discards all buffered and incoming entries.
- REQ-008 in_valid  input  NUM_CH  dispatch offers an entry on channel c.
- REQ-009 in_entry  input  NUM_CH*ENTRY_W  payload for channel c at bits [c*ENTRY_W +: ENTRY_W].
- REQ-010 in_ready  output  NUM_CH  channel c accepts an entry this cycle.
- REQ-011 out_valid  output  NUM_CH  channel c presents an entry to its execution unit.
- REQ-012 out_entry  output  NUM_CH*ENTRY_W  presented payload, same packing as in_entry.
- REQ-013 out_busy  input  NUM_CH  execution unit c cannot take an entry this cycle.
- REQ-014 count  output  NUM_CH*$clog2(DEPTH+1)  buffered entries per channel.

Function
- REQ-015 Each channel SHALL be an independent in-order FIFO; no interaction between channels.
- REQ-016 in_ready[c] SHALL be combinational: rst high && !flush && count[c] < DEPTH; it SHALL NOT depend on in_valid or out_busy.
- REQ-017 Push SHALL occur when in_valid[c] && in_ready[c], except under bypass consumption (REQ-020).
- REQ-018 Pop SHALL occur when out_valid[c] && !out_busy[c].
- REQ-019 With count[c] > 0, out_valid[c] SHALL be !flush and out_entry SHALL be the head entry.
- REQ-020 BYPASS=1, count[c]==0, in_valid[c], !flush: out_valid[c] SHALL be 1 in the same cycle with out_entry = in_entry; if out_busy[c]==0 the entry is consumed and not stored, else it is stored (count becomes 1).
- REQ-021 BYPASS=0: minimum latency in_valid -> out_valid is 1 cycle; out_valid SHALL be 0 when count[c]==0.
- REQ-022 Full channel with simultaneous pop: the pop SHALL occur, no push (in_ready already 0); count becomes DEPTH-1.
- REQ-023 Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, order preserved.
- REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
- REQ-025 flush SHALL combinationally force in_ready and out_valid to 0 on all channels; on the next edge pointers and counts SHALL be zero; storage contents need not be cleared.
- REQ-026 out_entry[c] is undefined while out_valid[c]==0; the bench SHALL NOT check it.

Reset
- REQ-027 rst low SHALL immediately clear all pointers and counts; out_valid=0, in_ready=0, count=0 on every channel.
- REQ-028 Reset asserted mid-operation SHALL discard all buffered entries; after release in_ready=1 on all channels in the first cycle.
- REQ-029 Storage arrays SHALL NOT be reset.

Structure
- REQ-030 NUM_ISSUE_CH and ISSUE_FIFO_DEPTH constants SHALL live in parameter_pkg; RS_ENTRY_t remains in typedef_pkg.
- REQ-031 One sub-module issue_fifo (single channel: storage, pointers, count, bypass) SHALL be instantiated NUM_CH times via generate.

Verification (NUM_CH=3, DEPTH=4, ENTRY_W=32 unless stated)
- REQ-032 ch0 out_busy=1, push 0xA1..0xA5 back-to-back -> in_ready[0]=0 after 4th, count=4, 0xA5 held off; drop out_busy -> 0xA1..0xA4 popped one per cycle, then 0xA5 accepted.
- REQ-033 BYPASS=1, ch2 empty, in_entry 0x55, out_busy=0 -> out_valid[2]=1 same cycle, out_entry=0x55, count stays 0; BYPASS=0 -> out_valid[2]=1 next cycle.
- REQ-034 ch1 count=3, flush=1 with in_valid=1 -> in_ready/out_valid 0 that cycle; next cycle count=0, no flushed entry ever presented.
- REQ-035 ch0 count=4, out_busy=0, in_valid=1 -> pop only, count=3; then 12 push/pop pairs 0x10..0x1B -> popped in order across pointer wrap.
- REQ-036 rst low for 1 cycle while ch0/ch1 hold 2/3 entries -> out_valid=0, count=0 immediately; after release in_ready=3'b111, no old entry reappears.
- REQ-037 ch0 stalled (out_busy[0]=1) while ch1/ch2 stream 8 entries each -> ch1/ch2 throughput 1 entry/cycle, ch0 unaffected.

Source files
------------

// File: rtl/issue_fifo_bank_pkg.sv
// Shared constants and types for the issue stage.
//
// parameter_pkg : sizing constants for the issue FIFO bank.
// typedef_pkg   : reservation-station entry layout and issue channel ids.
// No ports; packages only.

package parameter_pkg;

    localparam int NUM_ISSUE_CH     = 3;
    localparam int ISSUE_FIFO_DEPTH = 4;

endpackage

package typedef_pkg;

    // Channel numbering used by dispatch and by the execution units.
    typedef enum logic [1:0] {
        ISSUE_CH_ALU    = 2'd0,
        ISSUE_CH_LS     = 2'd1,
        ISSUE_CH_BRANCH = 2'd2
    } issue_ch_e;

    // One reservation-station entry as handed from dispatch to issue.
    typedef struct packed {
        logic [7:0] opcode;
        logic [5:0] rd_tag;
        logic [5:0] rs1_tag;
        logic [5:0] rs2_tag;
        logic [5:0] rob_idx;
    } RS_ENTRY_t;

endpackage

// File: rtl/issue_fifo_bank_issue_fifo.sv
// issue_fifo: one in-order issue channel (storage, pointers, count, bypass).
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   flush      discards buffered and incoming entries
//   in_valid   dispatch offers in_entry
//   in_entry   offered payload
//   in_ready   channel accepts an entry this cycle
//   out_valid  channel presents out_entry to its execution unit
//   out_entry  presented payload (head, or in_entry when bypassing)
//   out_busy   execution unit cannot take an entry this cycle
//   count      number of buffered entries

module issue_fifo #(
    parameter int ENTRY_W = 32,
    parameter int DEPTH   = 4,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [ENTRY_W-1:0]           in_entry,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [ENTRY_W-1:0]           out_entry,
    input  logic                         out_busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               empty;
    logic               pop;
    logic               pop_stored;
    logic               push;

    // Handshake decode. When the channel is empty and bypass is enabled the
    // incoming entry is shown directly; if the unit takes it in that same
    // cycle it is consumed and must not also be written into storage.
    always_comb begin
        empty      = (cnt == '0);
        in_ready   = rst && !flush && (cnt < FULL_CNT);
        out_valid  = rst && !flush && (!empty || (BYPASS && in_valid));
        out_entry  = empty ? in_entry : mem[rd_ptr];
        pop        = out_valid && !out_busy;
        pop_stored = pop && !empty;
        push       = in_valid && in_ready && !(pop && empty);
    end

    // Pointers and occupancy. Pointers are log2(DEPTH) wide so they wrap
    // naturally; flush behaves like a synchronous clear of the same state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_stored) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop_stored})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage is deliberately left out of reset; an entry is only
    // ever read after it has been written, since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    assign count = cnt;

endmodule

// File: rtl/issue_fifo_bank.sv
// issue_fifo_bank: NUM_CH independent in-order issue FIFOs, one per
// execution unit (0=ALU, 1=LS, 2=BRANCH), with optional same-cycle bypass.
//
// Ports (channel c occupies slice c of each vector):
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   flush      discards all buffered and incoming entries
//   in_valid   [NUM_CH]            dispatch offers an entry
//   in_entry   [NUM_CH*ENTRY_W]    payload, bits [c*ENTRY_W +: ENTRY_W]
//   in_ready   [NUM_CH]            channel accepts an entry this cycle
//   out_valid  [NUM_CH]            channel presents an entry
//   out_entry  [NUM_CH*ENTRY_W]    presented payload, same packing
//   out_busy   [NUM_CH]            execution unit cannot take an entry
//   count      [NUM_CH*CNT_W]      buffered entries per channel

module issue_fifo_bank
    import parameter_pkg::*;
    import typedef_pkg::*;
#(
    parameter int NUM_CH  = NUM_ISSUE_CH,
    parameter int ENTRY_W = $bits(RS_ENTRY_t),
    parameter int DEPTH   = ISSUE_FIFO_DEPTH,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [NUM_CH-1:0]                    in_valid,
    input  logic [NUM_CH*ENTRY_W-1:0]            in_entry,
    output logic [NUM_CH-1:0]                    in_ready,
    output logic [NUM_CH-1:0]                    out_valid,
    output logic [NUM_CH*ENTRY_W-1:0]            out_entry,
    input  logic [NUM_CH-1:0]                    out_busy,
    output logic [NUM_CH*$clog2(DEPTH+1)-1:0]    count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Channels share nothing but clock, reset and flush.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        issue_fifo #(
            .ENTRY_W (ENTRY_W),
            .DEPTH   (DEPTH),
            .BYPASS  (BYPASS)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid[c]),
            .in_entry  (in_entry[c*ENTRY_W +: ENTRY_W]),
            .in_ready  (in_ready[c]),
            .out_valid (out_valid[c]),
            .out_entry (out_entry[c*ENTRY_W +: ENTRY_W]),
            .out_busy  (out_busy[c]),
            .count     (count[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_issue_fifo_bank.sv
// Self-checking bench for issue_fifo_bank. Two instances (bypass on/off)
// receive identical stimulus and are compared every cycle against a
// queue-based reference model, plus directed literal expectations.

module tb_issue_fifo_bank;

    localparam int NCH = 3;
    localparam int EW  = 32;
    localparam int DP  = 4;
    localparam int CW  = 3;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [NCH-1:0]    in_valid;
    logic [NCH*EW-1:0] in_entry;
    logic [NCH-1:0]    out_busy;

    logic [NCH-1:0]    bp_in_ready, nb_in_ready;
    logic [NCH-1:0]    bp_out_valid, nb_out_valid;
    logic [NCH*EW-1:0] bp_out_entry, nb_out_entry;
    logic [NCH*CW-1:0] bp_count, nb_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Reference model: one queue per (instance, channel); instance 0 bypasses.
    logic [EW-1:0] mq [2][NCH][$];

    issue_fifo_bank #(.NUM_CH(NCH), .ENTRY_W(EW), .DEPTH(DP), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_entry(in_entry), .in_ready(bp_in_ready),
        .out_valid(bp_out_valid), .out_entry(bp_out_entry),
        .out_busy(out_busy), .count(bp_count)
    );

    issue_fifo_bank #(.NUM_CH(NCH), .ENTRY_W(EW), .DEPTH(DP), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_entry(in_entry), .in_ready(nb_in_ready),
        .out_valid(nb_out_valid), .out_entry(nb_out_entry),
        .out_busy(out_busy), .count(nb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_ready(int b, int c);
        return rst && !flush && (mq[b][c].size() < DP);
    endfunction

    function automatic bit m_valid(int b, int c);
        return rst && !flush && (mq[b][c].size() > 0 || (b == 0 && in_valid[c]));
    endfunction

    function automatic logic [EW-1:0] m_entry(int b, int c);
        if (mq[b][c].size() > 0) return mq[b][c][0];
        return in_entry[c*EW +: EW];
    endfunction

    function automatic int m_count(int b, int c);
        return rst ? mq[b][c].size() : 0;
    endfunction

    function automatic bit a_ready(int b, int c);
        return (b == 0) ? bp_in_ready[c] : nb_in_ready[c];
    endfunction

    function automatic bit a_valid(int b, int c);
        return (b == 0) ? bp_out_valid[c] : nb_out_valid[c];
    endfunction

    function automatic logic [EW-1:0] a_entry(int b, int c);
        return (b == 0) ? bp_out_entry[c*EW +: EW] : nb_out_entry[c*EW +: EW];
    endfunction

    function automatic int a_count(int b, int c);
        return (b == 0) ? int'(bp_count[c*CW +: CW]) : int'(nb_count[c*CW +: CW]);
    endfunction

    // Advance the model on each rising edge using the inputs held across it.
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!rst || flush) begin
                    mq[b][c].delete();
                end else begin
                    do_pop  = m_valid(b, c) && !out_busy[c];
                    do_push = in_valid[c] && m_ready(b, c);
                    if (!(do_pop && mq[b][c].size() == 0)) begin
                        if (do_pop) void'(mq[b][c].pop_front());
                        if (do_push) mq[b][c].push_back(in_entry[c*EW +: EW]);
                    end
                end
            end
        end
    end

    // Compare every output of both instances against the model mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NCH; c++) begin
                    checks++;
                    if (a_ready(b, c) !== m_ready(b, c)) begin
                        errors++;
                        $display("[TB] FAIL model b%0d ch%0d in_ready: got %0b want %0b at %0t",
                                 b, c, a_ready(b, c), m_ready(b, c), $time);
                    end
                    checks++;
                    if (a_valid(b, c) !== m_valid(b, c)) begin
                        errors++;
                        $display("[TB] FAIL model b%0d ch%0d out_valid: got %0b want %0b at %0t",
                                 b, c, a_valid(b, c), m_valid(b, c), $time);
                    end
                    checks++;
                    if (a_count(b, c) != m_count(b, c)) begin
                        errors++;
                        $display("[TB] FAIL model b%0d ch%0d count: got %0d want %0d at %0t",
                                 b, c, a_count(b, c), m_count(b, c), $time);
                    end
                    if (m_valid(b, c)) begin
                        checks++;
                        if (a_entry(b, c) !== m_entry(b, c)) begin
                            errors++;
                            $display("[TB] FAIL model b%0d ch%0d out_entry: got %h want %h at %0t",
                                     b, c, a_entry(b, c), m_entry(b, c), $time);
                        end
                    end
                end
            end
        end
    end

    // Drive one cycle's worth of inputs (called just after a rising edge).
    task automatic applyStimulus(input logic [NCH-1:0] v, input logic [EW-1:0] e0,
                                 input logic [EW-1:0] e1, input logic [EW-1:0] e2,
                                 input logic [NCH-1:0] busy, input logic fl);
        in_valid = v;
        in_entry = {e2, e1, e0};
        out_busy = busy;
        flush    = fl;
    endtask

    // Literal expectation, independent of the model.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int pops1, pops2;

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = '0;
        in_entry = '0;
        out_busy = '0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("reset count", 32'(bp_count), 32'h0);
        checkOutput("reset out_valid", 32'(bp_out_valid), 32'h0);
        checkOutput("reset in_ready", 32'(bp_in_ready), 32'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("release in_ready", 32'(bp_in_ready), 32'h7);
        step();

        $display("[TB] ch0 fill while stalled, then drain");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'b001, 32'hA1 + 32'(i), 32'h0, 32'h0, 3'b001, 1'b0);
            if (i == 4) begin
                @(negedge clk);
                checkOutput("full in_ready0", 32'(bp_in_ready[0]), 32'h0);
                checkOutput("full count0", 32'(bp_count[2:0]), 32'h4);
                checkOutput("full head0", bp_out_entry[31:0], 32'hA1);
            end
            step();
        end
        applyStimulus(3'b001, 32'hA5, 32'h0, 32'h0, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("full pop head", bp_out_entry[31:0], 32'hA1);
        checkOutput("full pop ready", 32'(bp_in_ready[0]), 32'h0);
        step();
        @(negedge clk);
        checkOutput("after pop head", bp_out_entry[31:0], 32'hA2);
        checkOutput("after pop count", 32'(bp_count[2:0]), 32'h3);
        step();
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        repeat (5) step();

        $display("[TB] ch2 bypass vs registered path");
        applyStimulus(3'b100, 32'h0, 32'h0, 32'h55, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("bypass valid2", 32'(bp_out_valid[2]), 32'h1);
        checkOutput("bypass entry2", bp_out_entry[95:64], 32'h55);
        checkOutput("nobypass valid2 same cycle", 32'(nb_out_valid[2]), 32'h0);
        step();
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("bypass count2", 32'(bp_count[8:6]), 32'h0);
        checkOutput("nobypass valid2 next", 32'(nb_out_valid[2]), 32'h1);
        checkOutput("nobypass entry2 next", nb_out_entry[95:64], 32'h55);
        step();

        $display("[TB] ch1 flush with pending input");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b010, 32'h0, 32'hC0 + 32'(i), 32'h0, 3'b010, 1'b0);
            step();
        end
        applyStimulus(3'b010, 32'h0, 32'hC3, 32'h0, 3'b010, 1'b1);
        @(negedge clk);
        checkOutput("flush in_ready", 32'(bp_in_ready), 32'h0);
        checkOutput("flush out_valid", 32'(bp_out_valid), 32'h0);
        step();
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("post flush count1", 32'(bp_count[5:3]), 32'h0);
        checkOutput("post flush valid1", 32'(nb_out_valid[1]), 32'h0);
        repeat (2) step();

        $display("[TB] ch0 full pop then wrap streaming");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b001, 32'h30 + 32'(i), 32'h0, 32'h0, 3'b001, 1'b0);
            step();
        end
        applyStimulus(3'b001, 32'hEE, 32'h0, 32'h0, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("full+valid ready0", 32'(bp_in_ready[0]), 32'h0);
        step();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(3'b001, 32'h10 + 32'(i), 32'h0, 32'h0, 3'b000, 1'b0);
            if (i == 0) begin
                @(negedge clk);
                checkOutput("pop-only count0", 32'(bp_count[2:0]), 32'h3);
            end
            step();
        end
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        repeat (5) step();

        $display("[TB] reset mid-operation");
        applyStimulus(3'b011, 32'h40, 32'h50, 32'h0, 3'b011, 1'b0);
        step();
        applyStimulus(3'b011, 32'h41, 32'h51, 32'h0, 3'b011, 1'b0);
        step();
        applyStimulus(3'b010, 32'h0, 32'h52, 32'h0, 3'b011, 1'b0);
        step();
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3'b011, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid reset out_valid", 32'(bp_out_valid), 32'h0);
        checkOutput("mid reset count", 32'(bp_count), 32'h0);
        step();
        rst = 1'b1;
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("mid reset release ready", 32'(bp_in_ready), 32'h7);
        checkOutput("mid reset no stale", 32'(nb_out_valid), 32'h0);
        step();

        $display("[TB] ch0 stalled, ch1/ch2 streaming");
        pops1 = 0;
        pops2 = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'b111, 32'h60 + 32'(i), 32'h70 + 32'(i), 32'h80 + 32'(i),
                          3'b001, 1'b0);
            @(negedge clk);
            if (bp_out_valid[1]) pops1++;
            if (bp_out_valid[2]) pops2++;
            step();
        end
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3'b001, 1'b0);
        @(negedge clk);
        checkOutput("stream pops ch1", 32'(pops1), 32'd8);
        checkOutput("stream pops ch2", 32'(pops2), 32'd8);
        checkOutput("stalled count0", 32'(bp_count[2:0]), 32'h4);
        step();
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        repeat (5) step();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                          3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                          ($urandom_range(0, 31) == 0));
            rst = ($urandom_range(0, 199) != 0);
            step();
        end
        rst = 1'b1;
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
